dcache_sram_arbiter: RTL and testbench
======================================

# dcache_sram_arbiter

Round-robin arbiter and sequencer that shares one set of data-cache tag/data SRAM ways between `NR_PORTS` requesters: load units, store unit and miss handler. It sits in front of the tag-compare/SRAM macro pair and grants at most one requester per cycle. It supports locked bursts, used for miss-handler refills and evictions, with a bounded lock length. It returns a per-port read-valid strobe aligned with SRAM read data one cycle after the grant.

## Interface
- `NR_PORTS`, 3, number of requesters (≥2)
- `NR_WAYS`, 8, SRAM ways (per-way enable width)
- `ADDR_WIDTH`, 12, SRAM index/offset address width
- `DATA_WIDTH`, 128, write data width
- `MAX_LOCK`, 8, max consecutive locked grants to one port (≥1)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_i`  in  NR_PORTS  per-port request
- `lock_i`  in  NR_PORTS  per-port request to keep priority next cycle
- `way_i`  in  NR_PORTS×NR_WAYS  per-port way enables
- `addr_i`  in  NR_PORTS×ADDR_WIDTH  per-port address
- `we_i`  in  NR_PORTS  per-port write enable
- `wdata_i`  in  NR_PORTS×DATA_WIDTH  per-port write data
- `be_i`  in  NR_PORTS×DATA_WIDTH/8  per-port byte enables
- `gnt_o`  out  NR_PORTS  one-hot-or-zero grant, same cycle
- `rvalid_o`  out  NR_PORTS  read data on SRAM output belongs to this port
- `sram_req_o`  out  NR_WAYS  way enables to SRAM
- `sram_addr_o`  out  ADDR_WIDTH  muxed address
- `sram_we_o`  out  1  muxed write enable
- `sram_wdata_o`  out  DATA_WIDTH  muxed write data
- `sram_be_o`  out  DATA_WIDTH/8  muxed byte enables

## Operation
- State: `ptr_q` (priority pointer, $clog2(NR_PORTS) bits), `lock_cnt_q` (0..MAX_LOCK), `rvalid_q` (NR_PORTS).
- Arbitration:
  - Winner is the first requesting port at or after `ptr_q`, wrapping modulo NR_PORTS.
  - `gnt_o` is combinational from `req_i` and state, and is zero when no `req_i` is set.
- SRAM mux:
  - While a port is granted, `sram_*` outputs carry that port's `way_i`/`addr_i`/`we_i`/`wdata_i`/`be_i`.
  - When no port is granted, all `sram_*` outputs are 0.
  - A grant with `way_i`=0 still consumes the slot.
- Pointer update on a grant to port k:
  - If `lock_i[k]`=1 and `lock_cnt_q` < MAX_LOCK-1: `ptr_q` stays k and `lock_cnt_q`+1.
  - Otherwise: `ptr_q` becomes (k+1) mod NR_PORTS and `lock_cnt_q` becomes 0.
  - The lock therefore yields after MAX_LOCK consecutive grants. This guarantees every requester a grant within NR_PORTS·MAX_LOCK cycles.
- No grant: `ptr_q` holds and `lock_cnt_q` becomes 0, so the lock is broken.
- `lock_i` of a non-granted port is ignored.
- Read valid: `rvalid_q[k]` is set to `gnt_o[k] & ~we_i[k]`. Granted writes produce no `rvalid_o`.

## Timing
- Reset values: `ptr_q`=0, `lock_cnt_q`=0, `rvalid_o`=0. `gnt_o`/`sram_*` are 0 while `req_i`=0.
- Grant and SRAM request occur in the same cycle as `req_i`, with 0-cycle arbitration latency.
- `rvalid_o` asserts exactly 1 cycle after a read grant, coincident with SRAM read data.
- Back-to-back grants are allowed every cycle.
- Simultaneous requests: exactly one grant per cycle; losers must hold `req_i` and their payload until granted.
- Reset mid-burst: lock and pointer clear asynchronously, and a pending `rvalid_o` is dropped.

## Test plan
- Reset, then idle: `gnt_o`=0, `sram_req_o`=0, `rvalid_o`=0 for 5 cycles.
- Ports 0,1,2 request continuously, no lock: grants cycle 0→1→2→0. Each read grant is followed next cycle by the matching `rvalid_o` bit.
- Port 2 read with `way_i`=8'h0F, `addr_i`=12'h0A4: `sram_req_o`=8'h0F and `sram_addr_o`=12'h0A4 in the same cycle; `rvalid_o`=3'b100 next cycle.
- Port 1 write (`we_i`=1) granted: `sram_we_o`=1 with port 1's data/`be_i`; `rvalid_o` stays 0.
- Port 2 with `lock_i`=1 for 20 cycles, ports 0 and 1 also requesting, MAX_LOCK=8: port 2 gets 8 consecutive grants, then port 0 and port 1 get one each, then port 2 gets 8 more.
- Assert `rst_ni`=0 during a port 2 locked burst: all outputs are 0 immediately. After release, simultaneous requests from ports 1 and 2 grant port 1 first (`ptr_q`=0).

Source files
------------

// File: rtl/dcache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_sram_arbiter
//
// Shares one set of data-cache tag/data SRAM ways between NR_PORTS requesters
// (load units, store unit, miss handler). At most one port is granted per
// cycle, round-robin from a priority pointer. A granted port may hold its
// priority with lock_i for up to MAX_LOCK consecutive grants, which miss
// handler refills/evictions use. Read grants produce a one-hot rvalid_o strobe
// one cycle later, aligned with the SRAM read data.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   req_i         per-port request
//   lock_i        per-port request to keep priority on the next cycle
//   way_i         per-port way enables       (NR_PORTS x NR_WAYS, port 0 in LSBs)
//   addr_i        per-port SRAM address      (NR_PORTS x ADDR_WIDTH)
//   we_i          per-port write enable
//   wdata_i       per-port write data        (NR_PORTS x DATA_WIDTH)
//   be_i          per-port byte enables      (NR_PORTS x DATA_WIDTH/8)
//   gnt_o         one-hot-or-zero grant, same cycle as the request
//   rvalid_o      SRAM read data this cycle belongs to this port
//   sram_req_o    way enables to the SRAM (granted port's way_i, else 0)
//   sram_addr_o   granted port's address, else 0
//   sram_we_o     granted port's write enable, else 0
//   sram_wdata_o  granted port's write data, else 0
//   sram_be_o     granted port's byte enables, else 0
// -----------------------------------------------------------------------------
module dcache_sram_arbiter #(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned NR_WAYS    = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS-1:0]              req_i,
    input  logic [NR_PORTS-1:0]              lock_i,
    input  logic [NR_PORTS*NR_WAYS-1:0]      way_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NR_PORTS-1:0]              we_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
    output logic [NR_PORTS-1:0]              gnt_o,
    output logic [NR_PORTS-1:0]              rvalid_o,
    output logic [NR_WAYS-1:0]               sram_req_o,
    output logic [ADDR_WIDTH-1:0]            sram_addr_o,
    output logic                             sram_we_o,
    output logic [DATA_WIDTH-1:0]            sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          sram_be_o
);

    localparam int unsigned PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    // Architectural state
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    lock_cnt_q;
    logic [NR_PORTS-1:0] rvalid_q;

    // Next-state values
    logic [PTR_W-1:0]    ptr_d_s;
    logic [CNT_W-1:0]    lock_cnt_d_s;
    logic [NR_PORTS-1:0] rvalid_d_s;

    // Arbitration results
    logic [PTR_W-1:0]    cand_s;
    logic                win_vld_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [NR_PORTS-1:0] gnt_s;

    // Muxed SRAM request
    logic [NR_WAYS-1:0]    sram_req_s;
    logic [ADDR_WIDTH-1:0] sram_addr_s;
    logic                  sram_we_s;
    logic [DATA_WIDTH-1:0] sram_wdata_s;
    logic [BE_W-1:0]       sram_be_s;

    // State register: pointer, lock counter and read-valid strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            ptr_q      <= ptr_d_s;
            lock_cnt_q <= lock_cnt_d_s;
            rvalid_q   <= rvalid_d_s;
        end
    end

    // Round-robin search: first requesting port at or after ptr_q, wrapping
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
        cand_s    = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            cand_s = PTR_W'((32'(ptr_q) + i) % NR_PORTS);
            if (!win_vld_s && req_i[cand_s]) begin
                win_vld_s = 1'b1;
                win_idx_s = cand_s;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // One-hot grant decode of the winning index
    always_comb begin
        gnt_s = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            if (win_vld_s && (win_idx_s == PTR_W'(k))) begin
                gnt_s[k] = 1'b1;
            end else begin
                gnt_s[k] = 1'b0;
            end
        end
    end

    // AND-OR payload mux; all-zero when nothing is granted
    always_comb begin
        sram_req_s   = '0;
        sram_addr_s  = '0;
        sram_we_s    = 1'b0;
        sram_wdata_s = '0;
        sram_be_s    = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            if (gnt_s[k]) begin
                sram_req_s   = sram_req_s   | way_i[k*NR_WAYS +: NR_WAYS];
                sram_addr_s  = sram_addr_s  | addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sram_we_s    = sram_we_s    | we_i[k];
                sram_wdata_s = sram_wdata_s | wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                sram_be_s    = sram_be_s    | be_i[k*BE_W +: BE_W];
            end else begin
                sram_req_s   = sram_req_s;
            end
        end
    end

    // Next-state: a locked grant keeps priority until MAX_LOCK grants have
    // been taken in a row; any unlocked grant or idle cycle breaks the lock.
    always_comb begin
        ptr_d_s      = ptr_q;
        lock_cnt_d_s = '0;
        rvalid_d_s   = gnt_s & ~we_i;
        if (win_vld_s) begin
            if (lock_i[win_idx_s] && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
                ptr_d_s      = win_idx_s;
                lock_cnt_d_s = lock_cnt_q + CNT_W'(1);
            end else begin
                if (win_idx_s == PTR_W'(NR_PORTS - 1)) begin
                    ptr_d_s = '0;
                end else begin
                    ptr_d_s = win_idx_s + PTR_W'(1);
                end
                lock_cnt_d_s = '0;
            end
        end else begin
            ptr_d_s      = ptr_q;
            lock_cnt_d_s = '0;
        end
    end

    // Output drive: grant and SRAM request are same-cycle, rvalid is registered
    always_comb begin
        gnt_o        = gnt_s;
        rvalid_o     = rvalid_q;
        sram_req_o   = sram_req_s;
        sram_addr_o  = sram_addr_s;
        sram_we_o    = sram_we_s;
        sram_wdata_o = sram_wdata_s;
        sram_be_o    = sram_be_s;
    end

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dcache_sram_arbiter: directed stimulus, a cycle-level reference
// model of the arbitration rules checked on every falling edge, plus literal
// expectations for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_dcache_sram_arbiter;

    localparam int NP  = 3;
    localparam int NW  = 8;
    localparam int AW  = 12;
    localparam int DW  = 128;
    localparam int BW  = DW / 8;
    localparam int MXL = 8;

    logic              clk_i;
    logic              rst_ni;
    logic [NP-1:0]     req_i;
    logic [NP-1:0]     lock_i;
    logic [NP*NW-1:0]  way_i;
    logic [NP*AW-1:0]  addr_i;
    logic [NP-1:0]     we_i;
    logic [NP*DW-1:0]  wdata_i;
    logic [NP*BW-1:0]  be_i;
    logic [NP-1:0]     gnt_o;
    logic [NP-1:0]     rvalid_o;
    logic [NW-1:0]     sram_req_o;
    logic [AW-1:0]     sram_addr_o;
    logic              sram_we_o;
    logic [DW-1:0]     sram_wdata_o;
    logic [BW-1:0]     sram_be_o;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_sram_arbiter #(
        .NR_PORTS  (NP),
        .NR_WAYS   (NW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_LOCK  (MXL)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .way_i       (way_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .sram_req_o  (sram_req_o),
        .sram_addr_o (sram_addr_o),
        .sram_we_o   (sram_we_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_be_o   (sram_be_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic [NW-1:0] w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] b);
        way_i[p*NW +: NW]   = w;
        addr_i[p*AW +: AW]  = a;
        wdata_i[p*DW +: DW] = d;
        be_i[p*BW +: BW]    = b;
    endtask

    // ---------------- reference model ----------------
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic [NP-1:0] m_rv  = '0;
    int            m_win;
    logic [NP-1:0] e_gnt;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_ptr = 0;
            m_cnt = 0;
            m_rv  = '0;
        end
        m_win = -1;
        for (int i = 0; i < NP; i++) begin
            if (m_win < 0 && req_i[(m_ptr + i) % NP]) m_win = (m_ptr + i) % NP;
        end
        e_gnt = (m_win >= 0) ? NP'(1 << m_win) : '0;
        chk("m_gnt", DW'(gnt_o), DW'(e_gnt));
        chk("m_rvalid", DW'(rvalid_o), DW'(m_rv));
        if (m_win >= 0) begin
            chk("m_sram_req", DW'(sram_req_o), DW'(way_i[m_win*NW +: NW]));
            chk("m_sram_addr", DW'(sram_addr_o), DW'(addr_i[m_win*AW +: AW]));
            chk("m_sram_we", DW'(sram_we_o), DW'(we_i[m_win]));
            chk("m_sram_wdata", sram_wdata_o, wdata_i[m_win*DW +: DW]);
            chk("m_sram_be", DW'(sram_be_o), DW'(be_i[m_win*BW +: BW]));
        end else begin
            chk("m_sram_idle", DW'({sram_req_o, sram_addr_o, sram_we_o, sram_be_o}), '0);
            chk("m_sram_wdata_idle", sram_wdata_o, '0);
        end
        if (rst_ni) begin
            m_rv = e_gnt & ~we_i;
            if (m_win >= 0) begin
                if (lock_i[m_win] && m_cnt < MXL - 1) begin
                    m_ptr = m_win;
                    m_cnt = m_cnt + 1;
                end else begin
                    m_ptr = (m_win + 1) % NP;
                    m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int lock_seq [20] = '{2,2,2,2,2,2,2,2,0,1,2,2,2,2,2,2,2,2,0,1};

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni  = 1'b1;
        req_i   = '0;
        lock_i  = '0;
        way_i   = '0;
        addr_i  = '0;
        we_i    = '0;
        wdata_i = '0;
        be_i    = '0;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("idle_gnt", DW'(gnt_o), '0);
            chk("idle_sram_req", DW'(sram_req_o), '0);
            chk("idle_rvalid", DW'(rvalid_o), '0);
            next_cycle();
        end

        // Three-way round robin, reads only
        set_port(0, 8'h01, 12'h100, 128'h1111, 16'h000F);
        set_port(1, 8'h02, 12'h200, 128'h2222, 16'h00F0);
        set_port(2, 8'h04, 12'h300, 128'h3333, 16'h0F00);
        req_i = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk("rr_gnt", DW'(gnt_o), DW'(3'b001 << (c % 3)));
            if (c > 0) chk("rr_rvalid", DW'(rvalid_o), DW'(3'b001 << ((c - 1) % 3)));
            else       chk("rr_rvalid0", DW'(rvalid_o), '0);
            next_cycle();
        end

        // Port 2 read with specific way/addr
        req_i = 3'b100;
        set_port(2, 8'h0F, 12'h0A4, 128'h0, 16'hFFFF);
        @(negedge clk_i);
        chk("p2_gnt", DW'(gnt_o), DW'(3'b100));
        chk("p2_sram_req", DW'(sram_req_o), DW'(8'h0F));
        chk("p2_sram_addr", DW'(sram_addr_o), DW'(12'h0A4));
        next_cycle();
        req_i = 3'b000;
        @(negedge clk_i);
        chk("p2_rvalid", DW'(rvalid_o), DW'(3'b100));
        chk("p2_gnt_after", DW'(gnt_o), '0);
        next_cycle();

        // Port 1 write
        req_i = 3'b010;
        we_i  = 3'b010;
        set_port(1, 8'h80, 12'h3FF, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 16'hA5C3);
        @(negedge clk_i);
        chk("wr_gnt", DW'(gnt_o), DW'(3'b010));
        chk("wr_sram_we", DW'(sram_we_o), DW'(1'b1));
        chk("wr_sram_wdata", sram_wdata_o, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        chk("wr_sram_be", DW'(sram_be_o), DW'(16'hA5C3));
        next_cycle();
        req_i = 3'b000;
        we_i  = 3'b000;
        @(negedge clk_i);
        chk("wr_no_rvalid", DW'(rvalid_o), '0);
        next_cycle();

        // Locked burst from port 2 against ports 0 and 1 (pointer now at 2)
        req_i  = 3'b111;
        lock_i = 3'b100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk("lock_gnt", DW'(gnt_o), DW'(3'b001 << lock_seq[c]));
            next_cycle();
        end
        req_i  = 3'b000;
        lock_i = 3'b000;
        next_cycle();

        // Reset in the middle of a port 2 locked burst with a read pending
        req_i  = 3'b100;
        lock_i = 3'b100;
        repeat (3) next_cycle();
        chk("rst_pre_rvalid", DW'(rvalid_o), DW'(3'b100));
        rst_ni = 1'b0;
        req_i  = 3'b000;
        lock_i = 3'b000;
        #1;
        chk("rst_rvalid", DW'(rvalid_o), '0);
        chk("rst_gnt", DW'(gnt_o), '0);
        chk("rst_sram_req", DW'(sram_req_o), '0);
        @(negedge clk_i);
        next_cycle();
        rst_ni = 1'b1;
        req_i  = 3'b110;
        @(negedge clk_i);
        chk("post_rst_gnt1", DW'(gnt_o), DW'(3'b010));
        next_cycle();
        @(negedge clk_i);
        chk("post_rst_gnt2", DW'(gnt_o), DW'(3'b100));
        next_cycle();
        req_i = 3'b000;
        repeat (2) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
